led_fade_driver: RTL and testbench
==================================

# led_fade_driver

Output stage between the LED pattern source and the eight board LEDs on the MachXO2 board, clocked from the internal OSCH oscillator.
- Accepts an 8-bit pattern through a valid/ready style load.
- Drives the LEDs with 8-bit PWM brightness.
- Changes pattern by fading the old one out to zero, swapping, then fading the new one in to the requested brightness.
- All level changes land on PWM frame boundaries, so no frame is ever truncated.

## Interface
- PRESCALE, default 16: osc_clk cycles per PWM step; legal range 1..65535.
- FADE_DIV, default 8: PWM frames per fade step of ±1 level; legal range 1..255.
- osc_clk  in  1  sole clock, from OSCH.
- nreset  in  1  asynchronous, active-low reset; one clock; reset is asynchronous and active-low.
- pattern  in  8  new LED pattern, sampled on accepted load.
- load  in  1  request; accepted in any cycle where load && ready.
- brightness  in  8  target PWM level, 0 = off, 255 = 255/256 duty.
- ready  out  1  high in IDLE only.
- LED  out  8  registered PWM outputs, active high.

## Operation
- **Prescaler:** counts 0..PRESCALE-1 and wraps. tick is asserted when it equals PRESCALE-1.
- **PWM counter:** pwm_cnt is 8 bits and increments on tick, wrapping 255→0. frame_end = tick && pwm_cnt==255.
- **Registers:**
  - level (8 bits): current duty.
  - shown (8 bits): displayed pattern.
  - pending (8 bits): next pattern.
  - target (8 bits): brightness captured at load.
  - fade_cnt: counts frame_ends 0..FADE_DIV-1.
- **LED output:** LED <= shown & {8{pwm_cnt < level}}, registered.
- **FSM states:** IDLE, FADE_OUT, SWAP, FADE_IN.
  - IDLE:
    - ready=1.
    - At each frame_end, level <= brightness (live tracking).
    - On load && ready: pending <= pattern, target <= brightness, fade_cnt <= 0, go to FADE_OUT.
  - FADE_OUT:
    - At each frame_end, fade_cnt advances.
    - When fade_cnt==FADE_DIV-1: fade_cnt <= 0 and level <= level-1.
    - If level==0 at any frame_end, go to SWAP without decrementing.
  - SWAP: one cycle. shown <= pending, fade_cnt <= 0, go to FADE_IN.
  - FADE_IN:
    - At each frame_end, if level==target go to IDLE.
    - Otherwise, when fade_cnt==FADE_DIV-1, level <= level+1.
    - target==0 therefore returns to IDLE at the first frame_end.
- **Ignored inputs:**
  - load while ready==0 is ignored; there is no queueing.
  - brightness changes outside IDLE are ignored until IDLE resumes.
- **Arithmetic:** level never wraps. Decrements stop at 0; increments stop at target.
- **Reset:** nreset low clears everything asynchronously. State returns to IDLE from any state, including mid-fade.

## Timing
- **Reset values:** LED=0, ready=1, level=0, shown=0, pending=0, target=0, pwm_cnt=0, prescaler=0, fade_cnt=0.
- **Frame length:** 256·PRESCALE cycles.
- **Duty:** LED[i] with shown[i]=1 is high for exactly level·PRESCALE cycles per frame, starting at the cycle after pwm_cnt becomes 0 (one-cycle output register latency).
- **Handshake:**
  - ready falls in the cycle after an accepted load.
  - ready rises in the cycle after the frame_end that satisfies level==target in FADE_IN.
- **Swap latency:** frame_end(level==0) → SWAP → shown updated 2 cycles later. This always occurs with level==0, so no visible glitch.
- **Fade duration:** from level L0 to target T, total frame_ends in flight ≈ (L0+T)·FADE_DIV + 2.
- **Simultaneous events:**
  - load coinciding with frame_end in IDLE: the level update to brightness still applies, then FADE_OUT starts from that level.
  - nreset deassertion: the first tick comes PRESCALE cycles after release.

## Test plan
- **Reset mid-fade** (PRESCALE=1, FADE_DIV=1): assert nreset low during FADE_IN → LED=8'h00 and ready=1 immediately (asynchronous, no clock edge); all state at reset values after release.
- **Idle brightness** (PRESCALE=1): after a completed load of 8'hA5, set brightness=64 → from the next full frame, LED bits 0,2,5,7 are high 64 of 256 cycles each; bits 1,3,4,6 stay 0. brightness=255 → 255 of 256; brightness=0 → always 0.
- **Frame-boundary rule:** change brightness 128→32 at pwm_cnt=10 → the current frame still shows 128 cycles high; the next frame shows 32.
- **Fade sequence** (PRESCALE=1, FADE_DIV=1, level 4, shown 8'hFF): load pattern=8'h0F with brightness=4.
  - Per-frame high counts are 4,3,2,1,0 on 8'hFF.
  - Then 0,1,2,3,4 on 8'h0F only.
  - ready returns high after the frame_end where level==4.
- **Busy load:** assert load with 8'h3C while ready=0 → ignored; the final shown pattern is the originally accepted one. A load with 8'h3C one cycle after ready rises is accepted.
- **Edge targets:** load with brightness=0 → FADE_IN exits at its first frame_end, with LED constantly 0. A PRESCALE=3 run confirms a frame is 768 cycles and high time is 3·level cycles.

Source files
------------

// File: rtl/led_fade_driver.sv
// led_fade_driver: eight-channel PWM LED stage with fade-out / swap / fade-in
// pattern changes. All level and pattern updates happen on PWM frame
// boundaries, so the duty of a frame is never cut short.
//
// Load handshake: a load is accepted on any rising osc_clk edge where
// load && ready. ready is high only in IDLE. The pattern and brightness
// inputs are sampled on that same edge. A load while ready is low is
// dropped; nothing is queued.
module led_fade_driver #(
  parameter int unsigned PRESCALE = 16,  // osc_clk cycles per PWM step, 1..65535
  parameter int unsigned FADE_DIV = 8    // PWM frames per fade step, 1..255
) (
  input  logic       osc_clk,
  input  logic       nreset,
  input  logic [7:0] pattern,
  input  logic       load,
  input  logic [7:0] brightness,
  output logic       ready,
  output logic [7:0] LED,
  output logic [1:0] dbg_state_o
);

  localparam logic [15:0] PRESC_MAX = 16'(PRESCALE - 1);
  localparam logic [7:0]  FADE_MAX  = 8'(FADE_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_FADE_OUT = 2'd1,
    S_SWAP     = 2'd2,
    S_FADE_IN  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] presc_q;
  logic [7:0]  pwm_cnt_q;
  logic [7:0]  level_q, level_d;
  logic [7:0]  shown_q, shown_d;
  logic [7:0]  pending_q, pending_d;
  logic [7:0]  target_q, target_d;
  logic [7:0]  fade_cnt_q, fade_cnt_d;
  logic [7:0]  led_q;
  logic        tick;
  logic        frame_end;

  assign tick        = (presc_q == PRESC_MAX);
  assign frame_end   = tick && (pwm_cnt_q == 8'hFF);
  assign ready       = (state_q == S_IDLE);
  assign LED         = led_q;
  assign dbg_state_o = state_q;

  // Prescaler and PWM step counter: one PWM step every PRESCALE cycles.
  always_ff @(posedge osc_clk or negedge nreset) begin
    if (!nreset) begin
      presc_q   <= '0;
      pwm_cnt_q <= '0;
    end else begin
      presc_q <= tick ? 16'd0 : presc_q + 16'd1;
      if (tick) begin
        pwm_cnt_q <= pwm_cnt_q + 8'd1;
      end
    end
  end

  // FSM next state plus level/pattern bookkeeping; updates gated by frame_end.
  always_comb begin
    state_d    = state_q;
    level_d    = level_q;
    shown_d    = shown_q;
    pending_d  = pending_q;
    target_d   = target_q;
    fade_cnt_d = fade_cnt_q;
    case (state_q)
      S_IDLE: begin
        // Live brightness tracking; a coinciding load fades from this level.
        if (frame_end) begin
          level_d = brightness;
        end
        if (load) begin
          pending_d  = pattern;
          target_d   = brightness;
          fade_cnt_d = 8'd0;
          state_d    = S_FADE_OUT;
        end
      end
      S_FADE_OUT: begin
        if (frame_end) begin
          if (level_q == 8'd0) begin
            state_d = S_SWAP;
          end else if (fade_cnt_q == FADE_MAX) begin
            fade_cnt_d = 8'd0;
            level_d    = level_q - 8'd1;
          end else begin
            fade_cnt_d = fade_cnt_q + 8'd1;
          end
        end
      end
      S_SWAP: begin
        // Level is zero here, so switching the pattern is invisible.
        shown_d    = pending_q;
        fade_cnt_d = 8'd0;
        state_d    = S_FADE_IN;
      end
      S_FADE_IN: begin
        // Level starts at 0 and target >= 0, so level never passes target.
        if (frame_end) begin
          if (level_q == target_q) begin
            state_d = S_IDLE;
          end else if (fade_cnt_q == FADE_MAX) begin
            fade_cnt_d = 8'd0;
            level_d    = level_q + 8'd1;
          end else begin
            fade_cnt_d = fade_cnt_q + 8'd1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // FSM and datapath registers.
  always_ff @(posedge osc_clk or negedge nreset) begin
    if (!nreset) begin
      state_q    <= S_IDLE;
      level_q    <= '0;
      shown_q    <= '0;
      pending_q  <= '0;
      target_q   <= '0;
      fade_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      level_q    <= level_d;
      shown_q    <= shown_d;
      pending_q  <= pending_d;
      target_q   <= target_d;
      fade_cnt_q <= fade_cnt_d;
    end
  end

  // Registered PWM output: high while the step count is below the level.
  always_ff @(posedge osc_clk or negedge nreset) begin
    if (!nreset) begin
      led_q <= '0;
    end else begin
      led_q <= shown_q & {8{pwm_cnt_q < level_q}};
    end
  end

endmodule

// File: tb/tb_led_fade_driver.sv
// Directed bench for led_fade_driver: one instance with PRESCALE=1,
// FADE_DIV=1 for the fade/handshake/frame tests and one with PRESCALE=3
// for frame length and duty scaling. Frames are located with a bench-side
// edge counter that restarts at reset release.
module tb_led_fade_driver;

  logic       osc_clk = 1'b0;
  logic       nreset  = 1'b0;
  logic [7:0] pattern = 8'h00;
  logic       load    = 1'b0;
  logic [7:0] brightness = 8'h00;
  logic       ready;
  logic [7:0] led;
  logic [1:0] dbg_state;

  logic [7:0] pattern3 = 8'h00;
  logic       load3    = 1'b0;
  logic [7:0] bright3  = 8'h00;
  logic       ready3;
  logic [7:0] led3;
  logic [1:0] dbg_state3;

  int compared   = 0;
  int mismatched = 0;
  int cyc;
  int cnt [8];
  int first_hi, last_hi;
  int rdy_first, rdy_last;

  led_fade_driver #(.PRESCALE(1), .FADE_DIV(1)) dut (
    .osc_clk(osc_clk), .nreset(nreset), .pattern(pattern), .load(load),
    .brightness(brightness), .ready(ready), .LED(led), .dbg_state_o(dbg_state)
  );

  led_fade_driver #(.PRESCALE(3), .FADE_DIV(1)) dut3 (
    .osc_clk(osc_clk), .nreset(nreset), .pattern(pattern3), .load(load3),
    .brightness(bright3), .ready(ready3), .LED(led3), .dbg_state_o(dbg_state3)
  );

  // Clock and edge counter (edges since reset release).
  always #5 osc_clk = ~osc_clk;

  always @(posedge osc_clk or negedge nreset) begin
    if (!nreset) cyc <= 0;
    else         cyc <= cyc + 1;
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    compared++;
    if (got != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Measure the next full frame of length f (in cycles). Optional action
  // at sample index 'at': 1 = set brightness, 2 = pulse load with pattern.
  task automatic measure(input int sel, input int f, input int act,
                         input int at, input logic [7:0] val);
    logic [7:0] s;
    while (cyc % f != 0) @(negedge osc_clk);
    for (int b = 0; b < 8; b++) cnt[b] = 0;
    first_hi = 0;
    last_hi  = 0;
    for (int i = 1; i <= f; i++) begin
      @(negedge osc_clk);
      s = sel ? led3 : led;
      if (i == 1) rdy_first = sel ? ready3 : ready;
      if (i == f) rdy_last  = sel ? ready3 : ready;
      for (int b = 0; b < 8; b++) if (s[b]) cnt[b]++;
      if (s[0]) begin
        if (first_hi == 0) first_hi = i;
        last_hi = i;
      end
      if (act == 1 && i == at) brightness = val;
      if (act == 2 && i == at) begin pattern = val; load = 1'b1; end
      if (act == 2 && i == at + 1) load = 1'b0;
    end
  endtask

  task automatic check_frame(input string tag, input logic [7:0] pat, input int hi);
    for (int b = 0; b < 8; b++)
      check_eq($sformatf("%s_bit%0d", tag, b), cnt[b], pat[b] ? hi : 0);
  endtask

  task automatic wait_ready(input int sel, input int budget, input string tag);
    int n = 0;
    while (!(sel ? ready3 : ready) && n < budget) begin
      @(negedge osc_clk);
      n++;
    end
    check_eq(tag, int'(sel ? ready3 : ready), 1);
  endtask

  logic [7:0] fo_pat [10] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
                              8'h0F, 8'h0F, 8'h0F, 8'h0F, 8'h0F};
  int         fo_lvl [10] = '{4, 3, 2, 1, 0, 0, 1, 2, 3, 4};

  initial begin
    int n, nz;
    // Reset state
    repeat (3) @(negedge osc_clk);
    check_eq("rst_led", led, 0);
    check_eq("rst_ready", ready, 1);
    check_eq("rst_ready3", ready3, 1);
    check_eq("rst_state", dbg_state, 0);
    nreset = 1'b1;
    @(negedge osc_clk);                      // cyc = 1
    check_eq("rel_led", led, 0);

    // Load A5 with brightness 0 (and FF/5 into the PRESCALE=3 instance)
    pattern = 8'hA5; brightness = 8'd0; load = 1'b1;
    pattern3 = 8'hFF; bright3 = 8'd5; load3 = 1'b1;
    @(negedge osc_clk);
    load = 1'b0; load3 = 1'b0;
    check_eq("t2_ready_fall", ready, 0);
    check_eq("t2_ready3_fall", ready3, 0);
    n = 0; nz = 0;
    while (!ready && n < 2000) begin
      @(negedge osc_clk);
      n++;
      if (led != 8'h00) nz++;
    end
    check_eq("t2_ready_rise", ready, 1);
    check_eq("t2_rise_cyc", cyc, 512);
    check_eq("t2_led_dark", nz, 0);

    // Idle brightness tracking on A5
    brightness = 8'd64;  @(negedge osc_clk); measure(0, 256, 0, 0, 8'h00);
    check_frame("b64", 8'hA5, 64);
    check_eq("b64_first", first_hi, 1);
    check_eq("b64_last", last_hi, 64);
    brightness = 8'd255; @(negedge osc_clk); measure(0, 256, 0, 0, 8'h00);
    check_frame("b255", 8'hA5, 255);
    brightness = 8'd0;   @(negedge osc_clk); measure(0, 256, 0, 0, 8'h00);
    check_frame("b0", 8'hA5, 0);

    // Frame-boundary rule: 128 -> 32 at pwm_cnt 10
    brightness = 8'd128; @(negedge osc_clk); measure(0, 256, 0, 0, 8'h00);
    measure(0, 256, 1, 10, 8'd32);
    check_frame("fb_cur", 8'hA5, 128);
    measure(0, 256, 0, 0, 8'h00);
    check_frame("fb_next", 8'hA5, 32);

    // Bring to level 4 on FF
    brightness = 8'd0; @(negedge osc_clk); measure(0, 256, 0, 0, 8'h00);
    pattern = 8'hFF; brightness = 8'd4; load = 1'b1;
    @(negedge osc_clk);
    load = 1'b0;
    wait_ready(0, 3000, "setup_ready");

    // Fade sequence FF@4 -> 0F@4, with an ignored busy load of 3C
    for (int k = 0; k < 10; k++) begin
      if (k == 0)      measure(0, 256, 2, 100, 8'h0F);
      else if (k == 2) measure(0, 256, 2, 50, 8'h3C);
      else             measure(0, 256, 0, 0, 8'h00);
      check_frame($sformatf("fade%0d", k), fo_pat[k], fo_lvl[k]);
      check_eq($sformatf("fade%0d_rdy", k), rdy_last, (k == 9) ? 1 : 0);
    end

    // Load 3C one cycle after ready rises: accepted
    @(negedge osc_clk);
    pattern = 8'h3C; load = 1'b1;
    @(negedge osc_clk);
    load = 1'b0;
    check_eq("c3_ready_fall", ready, 0);
    wait_ready(0, 4000, "c3_ready_rise");
    measure(0, 256, 0, 0, 8'h00);
    check_frame("c3", 8'h3C, 4);

    // PRESCALE=3: 768-cycle frames, 3*level high time
    wait_ready(1, 8000, "p3_ready");
    measure(1, 768, 0, 0, 8'h00);
    check_frame("p3", 8'hFF, 15);
    check_eq("p3_first", first_hi, 1);
    check_eq("p3_last", last_hi, 15);

    // Reset in the middle of FADE_IN
    brightness = 8'd200; pattern = 8'hAA; load = 1'b1;
    @(negedge osc_clk);
    load = 1'b0;
    repeat (2047) @(negedge osc_clk);
    @(negedge osc_clk);
    check_eq("mid_led", led, 8'hAA);
    check_eq("mid_ready", ready, 0);
    check_eq("mid_state", dbg_state, 3);
    #1 nreset = 1'b0;
    #1;
    check_eq("async_led", led, 0);
    check_eq("async_ready", ready, 1);
    check_eq("async_state", dbg_state, 0);
    check_eq("async_led3", led3, 0);
    @(negedge osc_clk);
    nreset = 1'b1;
    measure(0, 256, 0, 0, 8'h00);
    check_frame("post_rst", 8'hFF, 0);
    check_eq("post_rst_rdy_first", rdy_first, 1);
    check_eq("post_rst_rdy_last", rdy_last, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
